// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: standard mode constant sets, cfg bus
// field layout and the timing-set types.
// Ports: none (package).
package vga_timing_pkg;

  // One axis (horizontal in pixels or vertical in lines), wide enough for
  // any supported CNT_W.
  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] pw;
    logic [15:0] bp;
  } vga_axis_t;

  typedef struct packed {
    vga_axis_t hor;
    vga_axis_t ver;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    hor: '{active: 16'd640, fp: 16'd16, pw: 16'd96,  bp: 16'd48},
    ver: '{active: 16'd480, fp: 16'd10, pw: 16'd2,   bp: 16'd33}
  };

  localparam vga_timing_t VGA_800X600_60 = '{
    hor: '{active: 16'd800, fp: 16'd40, pw: 16'd128, bp: 16'd88},
    ver: '{active: 16'd600, fp: 16'd1,  pw: 16'd4,   bp: 16'd23}
  };

  // cfgHor/cfgVer are {active, fp, pw, bp}: field index 3 sits in the MSBs.
  localparam int unsigned CFG_BP_IDX     = 0;
  localparam int unsigned CFG_PW_IDX     = 1;
  localparam int unsigned CFG_FP_IDX     = 2;
  localparam int unsigned CFG_ACTIVE_IDX = 3;

  function automatic int unsigned cfg_lsb(int unsigned idx, int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap at active+fp+pw+bp-1, plus
// combinational sync-window and active-window decodes of the current count.
// Ports: clk_i/rst_n_i, en_i advances the count; timing fields in; count,
// wrap (count is last position), sync and active window flags out.
module vga_axis_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] active_i,
  input  logic [CNT_W-1:0] fp_i,
  input  logic [CNT_W-1:0] pw_i,
  input  logic [CNT_W-1:0] bp_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             sync_o,
  output logic             act_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sync_start, sync_end, last_pos;

  assign sync_start = active_i + fp_i;
  assign sync_end   = sync_start + pw_i;
  assign last_pos   = sync_end + bp_i - CNT_W'(1);

  // >= rather than == so a count can never run past the end of the axis.
  assign wrap_o = (cnt_q >= last_pos);
  assign sync_o = (cnt_q >= sync_start) && (cnt_q < sync_end);
  assign act_o  = (cnt_q < active_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a frame-synchronous runtime config update.
// Ports: ckVideo/rstVideo_n, enVideo count enable; cfgValid/cfgReady/cfgErr
// handshake with cfgHor/cfgVer sets; registered address, sync and flag outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int H_ACTIVE = int'(VGA_640X480_60.hor.active),
  parameter int H_FP     = int'(VGA_640X480_60.hor.fp),
  parameter int H_PW     = int'(VGA_640X480_60.hor.pw),
  parameter int H_BP     = int'(VGA_640X480_60.hor.bp),
  parameter int V_ACTIVE = int'(VGA_640X480_60.ver.active),
  parameter int V_FP     = int'(VGA_640X480_60.ver.fp),
  parameter int V_PW     = int'(VGA_640X480_60.ver.pw),
  parameter int V_BP     = int'(VGA_640X480_60.ver.bp),
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic               ckVideo,
  input  logic               rstVideo_n,
  input  logic               enVideo,
  input  logic               cfgValid,
  input  logic [4*CNT_W-1:0] cfgHor,
  input  logic [4*CNT_W-1:0] cfgVer,
  output logic               cfgReady,
  output logic               cfgErr,
  output logic [CNT_W-1:0]   adrHor,
  output logic [CNT_W-1:0]   adrVer,
  output logic               flgActiveVideo,
  output logic               HS,
  output logic               VS,
  output logic               flgLineStart,
  output logic               flgFrameStart
);

  typedef struct packed {
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] fp;
    logic [CNT_W-1:0] pw;
    logic [CNT_W-1:0] bp;
  } axis_t;

  localparam int unsigned ACT_LSB = cfg_lsb(CFG_ACTIVE_IDX, CNT_W);
  localparam int unsigned FP_LSB  = cfg_lsb(CFG_FP_IDX, CNT_W);
  localparam int unsigned PW_LSB  = cfg_lsb(CFG_PW_IDX, CNT_W);
  localparam int unsigned BP_LSB  = cfg_lsb(CFG_BP_IDX, CNT_W);

  localparam logic HS_LVL = 1'(HS_POL);
  localparam logic VS_LVL = 1'(VS_POL);

  localparam axis_t HOR_RST = '{active: CNT_W'(H_ACTIVE), fp: CNT_W'(H_FP),
                                pw: CNT_W'(H_PW), bp: CNT_W'(H_BP)};
  localparam axis_t VER_RST = '{active: CNT_W'(V_ACTIVE), fp: CNT_W'(V_FP),
                                pw: CNT_W'(V_PW), bp: CNT_W'(V_BP)};

  // A set is usable when active/pw/bp are non-zero and the total still
  // fits the counter; the sum is done two bits wider to catch overflow.
  function automatic logic set_ok(axis_t s);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, s.active} + {2'b00, s.fp} + {2'b00, s.pw} + {2'b00, s.bp};
    return (s.active != '0) && (s.pw != '0) && (s.bp != '0) &&
           (sum <= {2'b00, {CNT_W{1'b1}}});
  endfunction

  axis_t cfg_hor, cfg_ver;
  axis_t live_hor_q, live_hor_d, live_ver_q, live_ver_d;
  axis_t pend_hor_q, pend_hor_d, pend_ver_q, pend_ver_d;
  logic  pend_q, pend_d;
  logic  err_q, err_d;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, h_sync, h_act;
  logic             v_wrap, v_sync, v_act;
  logic             frame_end;

  assign cfg_hor = '{active: cfgHor[ACT_LSB +: CNT_W], fp: cfgHor[FP_LSB +: CNT_W],
                     pw: cfgHor[PW_LSB +: CNT_W], bp: cfgHor[BP_LSB +: CNT_W]};
  assign cfg_ver = '{active: cfgVer[ACT_LSB +: CNT_W], fp: cfgVer[FP_LSB +: CNT_W],
                     pw: cfgVer[PW_LSB +: CNT_W], bp: cfgVer[BP_LSB +: CNT_W]};

  vga_axis_counter #(.CNT_W(CNT_W)) u_hor (
    .clk_i    (ckVideo),
    .rst_n_i  (rstVideo_n),
    .en_i     (enVideo),
    .active_i (live_hor_q.active),
    .fp_i     (live_hor_q.fp),
    .pw_i     (live_hor_q.pw),
    .bp_i     (live_hor_q.bp),
    .cnt_o    (h_cnt),
    .wrap_o   (h_wrap),
    .sync_o   (h_sync),
    .act_o    (h_act)
  );

  vga_axis_counter #(.CNT_W(CNT_W)) u_ver (
    .clk_i    (ckVideo),
    .rst_n_i  (rstVideo_n),
    .en_i     (enVideo & h_wrap),
    .active_i (live_ver_q.active),
    .fp_i     (live_ver_q.fp),
    .pw_i     (live_ver_q.pw),
    .bp_i     (live_ver_q.bp),
    .cnt_o    (v_cnt),
    .wrap_o   (v_wrap),
    .sync_o   (v_sync),
    .act_o    (v_act)
  );

  // Both counters wrap to 0 on this edge, so swapping the live set here
  // keeps every frame on a single timing set.
  assign frame_end = enVideo & h_wrap & v_wrap;

  // The swap looks at pend_q from before this edge: a set accepted on the
  // boundary cycle itself waits for the next boundary.
  always_comb begin
    live_hor_d = live_hor_q;
    live_ver_d = live_ver_q;
    pend_hor_d = pend_hor_q;
    pend_ver_d = pend_ver_q;
    pend_d     = pend_q;
    err_d      = 1'b0;
    if (frame_end && pend_q) begin
      live_hor_d = pend_hor_q;
      live_ver_d = pend_ver_q;
      pend_d     = 1'b0;
    end else if (cfgValid && !pend_q) begin
      if (set_ok(cfg_hor) && set_ok(cfg_ver)) begin
        pend_hor_d = cfg_hor;
        pend_ver_d = cfg_ver;
        pend_d     = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ckVideo or negedge rstVideo_n) begin
    if (!rstVideo_n) begin
      live_hor_q <= HOR_RST;
      live_ver_q <= VER_RST;
      pend_hor_q <= '0;
      pend_ver_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      live_hor_q <= live_hor_d;
      live_ver_q <= live_ver_d;
      pend_hor_q <= pend_hor_d;
      pend_ver_q <= pend_ver_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  assign cfgReady = ~pend_q;
  assign cfgErr   = err_q;

  // Output stage: one register after the counters, frozen while disabled.
  logic [CNT_W-1:0] adr_hor_q, adr_ver_q;
  logic             act_q, hs_q, vs_q, ls_q, fs_q;

  always_ff @(posedge ckVideo or negedge rstVideo_n) begin
    if (!rstVideo_n) begin
      adr_hor_q <= '0;
      adr_ver_q <= '0;
      act_q     <= 1'b0;
      hs_q      <= ~HS_LVL;
      vs_q      <= ~VS_LVL;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else if (enVideo) begin
      adr_hor_q <= h_cnt;
      adr_ver_q <= v_cnt;
      act_q     <= h_act & v_act;
      hs_q      <= h_sync ? HS_LVL : ~HS_LVL;
      vs_q      <= v_sync ? VS_LVL : ~VS_LVL;
      ls_q      <= (h_cnt == '0);
      fs_q      <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign adrHor         = adr_hor_q;
  assign adrVer         = adr_ver_q;
  assign flgActiveVideo = act_q;
  assign HS             = hs_q;
  assign VS             = vs_q;
  assign flgLineStart   = ls_q;
  assign flgFrameStart  = fs_q;

endmodule
